// File: rtl/alu_issue_sequencer.sv
// alu_issue_sequencer
// -------------------
// Control stage in front of the ALU. It accepts one 20-bit instruction word per
// handshake and decodes it. It reads operands from an internal 8x20 register file
// and drives the ALU inputs for one cycle. One cycle later it captures the ALU's
// registered result and flags and writes the result back. SWAP does not go
// through the ALU; it is done here as two back-to-back writebacks.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   instr_valid/ready     instruction handshake (ready only in IDLE, low in reset)
//   instr_word[19:0]      {op[4:0], rd[2:0], rs1[2:0], rs2[2:0], use_imm, imm5[4:0]}
//   alu_instruction/a/b/cin   ALU inputs, non-zero only during ISSUE
//   alu_result/carry_out/flags ALU registered outputs, sampled in CAPTURE
//   wb_valid/wb_rd/wb_data    register write, committed at the end of that cycle
//   retire, illegal       one-cycle completion / undefined-op pulses
//   carry_flag, cmp_flags architectural carry and last compare {N,ZE}
//   dbg_raddr/dbg_rdata   combinational debug read port
module alu_issue_sequencer #(
    parameter int NREGS = 8,
    parameter int DW    = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [DW-1:0]     instr_word,
    output logic              instr_ready,
    output logic [13:0]       alu_instruction,
    output logic [DW-1:0]     alu_a,
    output logic [DW-1:0]     alu_b,
    output logic              alu_cin,
    input  logic [DW-1:0]     alu_result,
    input  logic              alu_carry_out,
    input  logic [12:0]       alu_flags,
    output logic              wb_valid,
    output logic [2:0]        wb_rd,
    output logic [DW-1:0]     wb_data,
    output logic              retire,
    output logic              illegal,
    output logic              carry_flag,
    output logic [1:0]        cmp_flags,
    input  logic [2:0]        dbg_raddr,
    output logic [DW-1:0]     dbg_rdata
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DECODE  = 3'd1,
        S_ISSUE   = 3'd2,
        S_CAPTURE = 3'd3,
        S_SWAP2   = 3'd4
    } state_t;

    // ALU opcode for op index k is 21*k-1 (k in 8..27).
    function automatic logic [13:0] op_code(input logic [4:0] idx);
        logic [13:0] k;
        k = {9'd0, idx};
        return (k * 14'd21) - 14'd1;
    endfunction

    state_t          state_q, state_d;
    logic [DW-1:0]   instr_q, instr_d;
    logic [DW-1:0]   hold_q, hold_d;          // old reg[rs1] for the SWAP2 write
    logic            carry_flag_q, carry_flag_d;
    logic [1:0]      cmp_flags_q, cmp_flags_d;
    logic [13:0]     alu_instruction_q, alu_instruction_d;
    logic [DW-1:0]   alu_a_q, alu_a_d;
    logic [DW-1:0]   alu_b_q, alu_b_d;
    logic            alu_cin_q, alu_cin_d;
    logic [DW-1:0]   regs_q [NREGS];
    logic [DW-1:0]   regs_d [NREGS];

    logic [4:0]      op_idx_s;
    logic [2:0]      rd_s, rs1_s, rs2_s;
    logic            use_imm_s;
    logic [4:0]      imm5_s;
    logic            is_nop_s, is_legal_s, is_swap_s, is_carry_op_s, is_cmp_s;
    logic [DW-1:0]   rs1_val_s, rs2_val_s, b_val_s;
    logic            unused_flags_s;

    assign op_idx_s      = instr_q[19:15];
    assign rd_s          = instr_q[14:12];
    assign rs1_s         = instr_q[11:9];
    assign rs2_s         = instr_q[8:6];
    assign use_imm_s     = instr_q[5];
    assign imm5_s        = instr_q[4:0];

    assign is_nop_s      = (op_idx_s == 5'd0);
    assign is_legal_s    = (op_idx_s >= 5'd8) && (op_idx_s <= 5'd27);
    assign is_swap_s     = (op_idx_s == 5'd16);
    assign is_carry_op_s = (op_idx_s == 5'd20) || (op_idx_s == 5'd22);
    assign is_cmp_s      = (op_idx_s >= 5'd23);

    assign rs1_val_s     = regs_q[rs1_s];
    assign rs2_val_s     = regs_q[rs2_s];
    assign b_val_s       = use_imm_s ? {{(DW-5){1'b0}}, imm5_s} : rs2_val_s;

    // Ready is forced low while reset is held, even though the FSM sits in IDLE.
    assign instr_ready     = rst_n && (state_q == S_IDLE);
    assign alu_instruction = alu_instruction_q;
    assign alu_a           = alu_a_q;
    assign alu_b           = alu_b_q;
    assign alu_cin         = alu_cin_q;
    assign carry_flag      = carry_flag_q;
    assign cmp_flags       = cmp_flags_q;
    assign dbg_rdata       = regs_q[dbg_raddr];
    assign unused_flags_s  = ^alu_flags[12:2];

    // Next-state, writeback strobes and register-file update.
    always_comb begin
        state_d           = state_q;
        instr_d           = instr_q;
        hold_d            = hold_q;
        carry_flag_d      = carry_flag_q;
        cmp_flags_d       = cmp_flags_q;
        alu_instruction_d = 14'd0;
        alu_a_d           = '0;
        alu_b_d           = '0;
        alu_cin_d         = 1'b0;
        wb_valid          = 1'b0;
        wb_rd             = 3'd0;
        wb_data           = '0;
        retire            = 1'b0;
        illegal           = 1'b0;
        regs_d            = regs_q;

        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr_word;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DECODE: begin
                if (is_nop_s) begin
                    retire  = 1'b1;
                    state_d = S_IDLE;
                end else if (!is_legal_s) begin
                    illegal = 1'b1;
                    retire  = 1'b1;
                    state_d = S_IDLE;
                end else if (is_swap_s) begin
                    wb_valid = 1'b1;
                    wb_rd    = rs1_s;
                    wb_data  = rs2_val_s;
                    hold_d   = rs1_val_s;
                    state_d  = S_SWAP2;
                end else begin
                    // ALU inputs are registered here so they are valid for exactly the ISSUE cycle.
                    alu_instruction_d = op_code(op_idx_s);
                    alu_a_d           = rs1_val_s;
                    alu_b_d           = b_val_s;
                    alu_cin_d         = is_carry_op_s ? carry_flag_q : 1'b0;
                    state_d           = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (is_cmp_s) begin
                    cmp_flags_d = alu_flags[1:0];
                end else begin
                    wb_valid = 1'b1;
                    wb_rd    = rd_s;
                    wb_data  = alu_result;
                end
                if (is_carry_op_s) begin
                    carry_flag_d = alu_carry_out;
                end else begin
                    carry_flag_d = carry_flag_q;
                end
                retire  = 1'b1;
                state_d = S_IDLE;
            end
            S_SWAP2: begin
                wb_valid = 1'b1;
                wb_rd    = rs2_s;
                wb_data  = hold_q;
                retire   = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (wb_valid) begin
            regs_d[wb_rd] = wb_data;
        end else begin
            regs_d[wb_rd] = regs_q[wb_rd];
        end
    end

    // State, architectural flags, ALU input registers and register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= S_IDLE;
            instr_q           <= '0;
            hold_q            <= '0;
            carry_flag_q      <= 1'b0;
            cmp_flags_q       <= 2'b00;
            alu_instruction_q <= 14'd0;
            alu_a_q           <= '0;
            alu_b_q           <= '0;
            alu_cin_q         <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q           <= state_d;
            instr_q           <= instr_d;
            hold_q            <= hold_d;
            carry_flag_q      <= carry_flag_d;
            cmp_flags_q       <= cmp_flags_d;
            alu_instruction_q <= alu_instruction_d;
            alu_a_q           <= alu_a_d;
            alu_b_q           <= alu_b_d;
            alu_cin_q         <= alu_cin_d;
            regs_q            <= regs_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Directed testbench for alu_issue_sequencer. The ALU is a stub: the bench
// sets alu_result/alu_carry_out/alu_flags by hand before each CAPTURE cycle.
module tb_alu_issue_sequencer;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [19:0] instr_word;
    logic        instr_ready;
    logic [13:0] alu_instruction;
    logic [19:0] alu_a;
    logic [19:0] alu_b;
    logic        alu_cin;
    logic [19:0] alu_result;
    logic        alu_carry_out;
    logic [12:0] alu_flags;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [19:0] wb_data;
    logic        retire;
    logic        illegal;
    logic        carry_flag;
    logic [1:0]  cmp_flags;
    logic [2:0]  dbg_raddr;
    logic [19:0] dbg_rdata;

    int n_checks = 0;
    int n_errors = 0;

    alu_issue_sequencer #(.NREGS(8), .DW(20)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .instr_valid     (instr_valid),
        .instr_word      (instr_word),
        .instr_ready     (instr_ready),
        .alu_instruction (alu_instruction),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_cin         (alu_cin),
        .alu_result      (alu_result),
        .alu_carry_out   (alu_carry_out),
        .alu_flags       (alu_flags),
        .wb_valid        (wb_valid),
        .wb_rd           (wb_rd),
        .wb_data         (wb_data),
        .retire          (retire),
        .illegal         (illegal),
        .carry_flag      (carry_flag),
        .cmp_flags       (cmp_flags),
        .dbg_raddr       (dbg_raddr),
        .dbg_rdata       (dbg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] mk(input int idx, input int rd, input int rs1,
                                       input int rs2, input int ui, input int imm);
        logic [19:0] w;
        w = {idx[4:0], rd[2:0], rs1[2:0], rs2[2:0], ui[0], imm[4:0]};
        return w;
    endfunction

    // Called at a negedge in IDLE; returns at the negedge of the DECODE cycle.
    task automatic send(input logic [19:0] w);
        check_eq("ready_before_send", 32'(instr_ready), 32'd1);
        instr_valid = 1'b1;
        instr_word  = w;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        instr_word  = 20'd0;
    endtask

    task automatic read_reg(input logic [2:0] a, input logic [19:0] exp, input string tag);
        dbg_raddr = a;
        #1;
        check_eq(tag, 32'(dbg_rdata), 32'(exp));
    endtask

    initial begin
        rst_n         = 1'b0;
        instr_valid   = 1'b0;
        instr_word    = 20'd0;
        alu_result    = 20'd0;
        alu_carry_out = 1'b0;
        alu_flags     = 13'd0;
        dbg_raddr     = 3'd0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_ready", 32'(instr_ready), 32'd0);
        check_eq("rst_alu_instr", 32'(alu_instruction), 32'd0);
        check_eq("rst_wb_valid", 32'(wb_valid), 32'd0);
        check_eq("rst_carry", 32'(carry_flag), 32'd0);
        check_eq("rst_cmp", 32'(cmp_flags), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD r1 = r0 + 5
        send(mk(19, 1, 0, 0, 1, 5));
        check_eq("add_dec_wb", 32'(wb_valid), 32'd0);
        @(negedge clk);
        check_eq("add_iss_op", 32'(alu_instruction), 32'h18E);
        check_eq("add_iss_a", 32'(alu_a), 32'd0);
        check_eq("add_iss_b", 32'(alu_b), 32'd5);
        check_eq("add_iss_cin", 32'(alu_cin), 32'd0);
        check_eq("add_iss_ready", 32'(instr_ready), 32'd0);
        alu_result = 20'd5;
        @(negedge clk);
        check_eq("add_cap_wbv", 32'(wb_valid), 32'd1);
        check_eq("add_cap_rd", 32'(wb_rd), 32'd1);
        check_eq("add_cap_data", 32'(wb_data), 32'd5);
        check_eq("add_cap_retire", 32'(retire), 32'd1);
        check_eq("add_cap_alu_off", 32'(alu_instruction), 32'd0);
        @(negedge clk);
        check_eq("add_idle_ready", 32'(instr_ready), 32'd1);
        check_eq("add_idle_wbv", 32'(wb_valid), 32'd0);
        read_reg(3'd1, 20'd5, "add_r1");

        // ADDC r2 = r1 + 3, ALU reports carry out
        send(mk(20, 2, 1, 0, 1, 3));
        @(negedge clk);
        check_eq("addc1_op", 32'(alu_instruction), 32'h1A3);
        check_eq("addc1_cin", 32'(alu_cin), 32'd0);
        alu_result    = 20'd8;
        alu_carry_out = 1'b1;
        @(negedge clk);
        check_eq("addc1_data", 32'(wb_data), 32'd8);
        @(negedge clk);
        check_eq("addc1_carry", 32'(carry_flag), 32'd1);

        // XOR r4 = r1 ^ r1 must leave carry untouched even with carry_out=0
        send(mk(11, 4, 1, 1, 0, 0));
        @(negedge clk);
        check_eq("xor_op", 32'(alu_instruction), 32'h0E6);
        check_eq("xor_b", 32'(alu_b), 32'd5);
        check_eq("xor_cin", 32'(alu_cin), 32'd0);
        alu_result    = 20'd0;
        alu_carry_out = 1'b0;
        @(negedge clk);
        check_eq("xor_rd", 32'(wb_rd), 32'd4);
        @(negedge clk);
        check_eq("xor_carry_kept", 32'(carry_flag), 32'd1);

        // Second ADDC r5 = r1 + 0 + cin
        send(mk(20, 5, 1, 0, 1, 0));
        @(negedge clk);
        check_eq("addc2_cin", 32'(alu_cin), 32'd1);
        check_eq("addc2_a", 32'(alu_a), 32'd5);
        alu_result    = 20'd6;
        alu_carry_out = 1'b0;
        @(negedge clk);
        check_eq("addc2_data", 32'(wb_data), 32'd6);
        @(negedge clk);
        check_eq("addc2_carry", 32'(carry_flag), 32'd0);
        read_reg(3'd5, 20'd6, "addc2_r5");

        // EQ r1,r1: flags only, no writeback
        send(mk(23, 1, 1, 1, 0, 0));
        @(negedge clk);
        check_eq("eq_op", 32'(alu_instruction), 32'h1E2);
        alu_result = 20'hABCDE;
        alu_flags  = 13'h001;
        @(negedge clk);
        check_eq("eq_wbv", 32'(wb_valid), 32'd0);
        check_eq("eq_retire", 32'(retire), 32'd1);
        @(negedge clk);
        check_eq("eq_cmp", 32'(cmp_flags), 32'd1);
        read_reg(3'd1, 20'd5, "eq_r1");
        alu_flags = 13'd0;

        // SWAP r1 (5) <-> r2 (8)
        send(mk(16, 0, 1, 2, 0, 0));
        check_eq("swp1_wbv", 32'(wb_valid), 32'd1);
        check_eq("swp1_rd", 32'(wb_rd), 32'd1);
        check_eq("swp1_data", 32'(wb_data), 32'd8);
        check_eq("swp1_retire", 32'(retire), 32'd0);
        check_eq("swp1_alu", 32'(alu_instruction), 32'd0);
        @(negedge clk);
        check_eq("swp2_wbv", 32'(wb_valid), 32'd1);
        check_eq("swp2_rd", 32'(wb_rd), 32'd2);
        check_eq("swp2_data", 32'(wb_data), 32'd5);
        check_eq("swp2_retire", 32'(retire), 32'd1);
        check_eq("swp2_alu", 32'(alu_instruction), 32'd0);
        @(negedge clk);
        check_eq("swp_ready", 32'(instr_ready), 32'd1);
        read_reg(3'd1, 20'd8, "swp_r1");
        read_reg(3'd2, 20'd5, "swp_r2");

        // Illegal op indices and NOP
        for (int i = 0; i < 3; i++) begin
            int idx;
            idx = (i == 0) ? 5 : ((i == 1) ? 30 : 0);
            send(mk(idx, 1, 2, 2, 0, 0));
            check_eq("ill_pulse", 32'(illegal), (i == 2) ? 32'd0 : 32'd1);
            check_eq("ill_retire", 32'(retire), 32'd1);
            check_eq("ill_wbv", 32'(wb_valid), 32'd0);
            @(negedge clk);
            check_eq("ill_back_idle", 32'(instr_ready), 32'd1);
            check_eq("ill_pulse_end", 32'(illegal), 32'd0);
        end
        read_reg(3'd1, 20'd8, "ill_r1");

        // Reset during ISSUE of ADD r3
        send(mk(19, 3, 1, 0, 1, 1));
        @(negedge clk);
        check_eq("mid_iss_op", 32'(alu_instruction), 32'h18E);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_op", 32'(alu_instruction), 32'd0);
        check_eq("mid_rst_a", 32'(alu_a), 32'd0);
        check_eq("mid_rst_ready", 32'(instr_ready), 32'd0);
        check_eq("mid_rst_cmp", 32'(cmp_flags), 32'd0);
        alu_result = 20'd9;
        @(negedge clk);
        check_eq("mid_rst_wbv", 32'(wb_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_ready", 32'(instr_ready), 32'd1);
        check_eq("post_rst_wbv", 32'(wb_valid), 32'd0);
        for (int r = 0; r < 8; r++) begin
            read_reg(r[2:0], 20'd0, "post_rst_reg");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
